alu_seq_exec: RTL and testbench
===============================

# alu_seq_exec

Sequential execute unit at the consuming end of the 4-bit `Operation` code produced by the ALU controller. It accepts an operation and two operands over a valid/ready handshake. Logic, arithmetic, compare and branch operations complete in one cycle. Shifts are iterated one bit per cycle. The registered result is held until the downstream stage (MEM/writeback) takes it.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and result width. Must be a power of two, at least 8.
- `SHAMT_W`, `$clog2(DATA_WIDTH)`: number of shift-amount bits taken from `SrcB`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `Operation`/`SrcA`/`SrcB` are valid.
- `in_ready` output 1: unit can accept an operation this cycle.
- `Operation` input 4: ALU operation code, in the same encoding the controller emits.
- `SrcA` input `DATA_WIDTH`: operand A (rs1).
- `SrcB` input `DATA_WIDTH`: operand B (rs2 or immediate).
- `out_valid` output 1: `ALUResult`/`BranchTaken` are valid.
- `out_ready` input 1: consumer accepts the result.
- `ALUResult` output `DATA_WIDTH`: registered result.
- `BranchTaken` output 1: branch condition result. Meaningful only with `out_valid`.

## Operation
Operation codes:
- `0000`/`1010`: add.
- `0001`: sub (A−B).
- `0010`: and.
- `0011`: or.
- `0100`: xor.
- `0101`: sll.
- `0110`: srl.
- `0111`: sra.
- `1000`/`1001`: signed set-less-than; result is 1 or 0, zero-extended.
- `1011`: beq.
- `1100`: bne.
- `1101`: blt (signed).
- `1110`: bge (signed).
- `1111`: pass B (lui).

Result rules:
- All arithmetic wraps modulo 2^`DATA_WIDTH`. No overflow flag.
- Shift amount is `SrcB[SHAMT_W-1:0]`. Upper bits of `SrcB` are ignored. `sra` replicates `SrcA[MSB]`.
- Branch ops: `BranchTaken` = condition, `ALUResult` = {0…, condition}.
- Non-branch ops: `BranchTaken` = 0.

FSM states:
- `IDLE`: `in_ready`=1. On `in_valid`:
  - Non-shift op: compute, register result, go to `DONE`.
  - Shift op with shamt=0: register `SrcA`, go to `DONE`.
  - Shift op with shamt>0: load `SrcA` into the shift register and shamt into the down-counter, go to `SHIFT`.
- `SHIFT`: `in_ready`=0. Each cycle, shift by 1 in the captured direction and decrement the counter. When the counter reaches 1 (last shift this cycle), go to `DONE`.
- `DONE`: `out_valid`=1. Outputs are held stable while `out_ready`=0.
  - On `out_ready`: if `in_valid` is also present, accept the new op as in `IDLE` (back-to-back); otherwise go to `IDLE`.
  - `in_ready` = `out_ready` in this state.

Capture and boundary rules:
- `Operation`, `SrcA`, `SrcB` are captured on the handshake. Later changes on those inputs have no effect.
- Reset (any state, including mid-`SHIFT`): state `IDLE`, counter 0, operation abandoned, no `out_valid` emitted for it.
- Undefined codes are impossible; all 16 codes are defined.

## Timing
- Reset values: `in_ready`=1 (`IDLE`), `out_valid`=0, `ALUResult`=0, `BranchTaken`=0.
- Latency from accept to `out_valid`:
  - Non-shift op, or shift with shamt=0: 1 cycle.
  - Shift with shamt=n>0: n+1 cycles.
- Throughput with `out_ready` held high: one non-shift op per cycle.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.
- `out_valid`, `ALUResult` and `BranchTaken` come directly from registers.

## Structure
- Package `alu_ops_pkg`: enum `alu_op_e` for the 16 codes, state enum `exec_state_e`, and helper functions `is_shift`/`is_branch`.
- Sub-module `alu_comb_core`: purely combinational single-cycle ops and branch compare.
- The top module owns the FSM, the shift register, the counter and the output registers.

## Test plan
- Reset, then `add` with A=5, B=7, `out_ready`=1 → `out_valid` next cycle, `ALUResult`=12, `BranchTaken`=0.
- `sub` with A=0, B=1 → `ALUResult`=0xFFFFFFFF. `slt` with A=0xFFFFFFFF, B=1 → `ALUResult`=1.
- `sra` with A=0x80000000, B=0x21 (shamt 1): `out_valid` 2 cycles after accept, `ALUResult`=0xC0000000. `sll` with A=1, shamt 31: `out_valid` 32 cycles after accept, `ALUResult`=0x80000000, `in_ready`=0 throughout `SHIFT`.
- Branch ops, each against `BranchTaken`:
  - `bge` with A=−1, B=0 → 0.
  - `blt` with the same operands → 1.
  - `beq` with 9,9 → 1.
  - `bne` with 9,9 → 0.
- Backpressure: result pending, `out_ready`=0 for 3 cycles while inputs change → `ALUResult` stable and `in_ready`=0. Raising `out_ready` with a new `in_valid` accepts the new op in the same cycle.
- Assert `rst_n` mid-`SHIFT` (shamt 20, cycle 5) → `IDLE` immediately, `out_valid`=0, no stale result after reset is released.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Purpose: shared operation codes, FSM state encoding and op-class helpers for alu_seq_exec.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_ops_pkg;

  // Encoding matches the 4-bit Operation code emitted by the ALU controller.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLT2  = 4'b1001,
    ALU_ADD2  = 4'b1010,
    ALU_BEQ   = 4'b1011,
    ALU_BNE   = 4'b1100,
    ALU_BLT   = 4'b1101,
    ALU_BGE   = 4'b1110,
    ALU_PASSB = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } exec_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_branch(alu_op_e op);
    return (op == ALU_BEQ) || (op == ALU_BNE) || (op == ALU_BLT) || (op == ALU_BGE);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purpose: combinational single-cycle ALU ops and branch compare.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register the result.
// Ports: op/a/b in; result = op result (shift ops pass a through, used for shamt=0);
//        branch_taken = branch condition, 0 for non-branch ops.
module alu_comb_core
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken
);

  logic lt_signed;
  logic eq;

  assign lt_signed = $signed(a) < $signed(b);
  assign eq        = (a == b);

  always_comb begin
    result       = '0;
    branch_taken = 1'b0;
    case (op)
      ALU_ADD, ALU_ADD2: result = a + b;
      ALU_SUB:           result = a - b;
      ALU_AND:           result = a & b;
      ALU_OR:            result = a | b;
      ALU_XOR:           result = a ^ b;
      // Shifts are iterated by the top; only the shamt=0 case uses this path.
      ALU_SLL, ALU_SRL, ALU_SRA: result = a;
      ALU_SLT, ALU_SLT2: result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      ALU_BEQ:           branch_taken = eq;
      ALU_BNE:           branch_taken = ~eq;
      ALU_BLT:           branch_taken = lt_signed;
      ALU_BGE:           branch_taken = ~lt_signed;
      ALU_PASSB:         result = b;
      default:           result = '0;
    endcase
    if (is_branch(op)) begin
      result = {{(DATA_WIDTH-1){1'b0}}, branch_taken};
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Purpose: sequential execute unit; one-cycle ALU/branch ops, bit-serial shifts, held result.
// Latency: 1 cycle from accept for non-shift ops and shamt=0; n+1 cycles for shamt=n>0.
// Backpressure: result held while out_ready=0; in_ready only in IDLE or DONE with out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with Operation, SrcA, SrcB;
//        out_valid/out_ready with registered ALUResult and BranchTaken.
module alu_seq_exec
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BranchTaken
);

  exec_state_e           state;
  alu_op_e               op_in;
  alu_op_e               sh_op;
  logic [DATA_WIDTH-1:0] sh_reg;
  logic [DATA_WIDTH-1:0] sh_next;
  logic [SHAMT_W-1:0]    cnt;
  logic [SHAMT_W-1:0]    shamt_in;
  logic [DATA_WIDTH-1:0] core_result;
  logic                  core_branch;
  logic                  accept;

  assign op_in    = alu_op_e'(Operation);
  assign shamt_in = SrcB[SHAMT_W-1:0];

  // Depends only on state and out_ready so no comb path from in_valid.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .op           (op_in),
    .a            (SrcA),
    .b            (SrcB),
    .result       (core_result),
    .branch_taken (core_branch)
  );

  // One-bit step in the direction captured at accept time.
  always_comb begin
    sh_next = sh_reg << 1;
    case (sh_op)
      ALU_SRL: sh_next = sh_reg >> 1;
      ALU_SRA: sh_next = {sh_reg[DATA_WIDTH-1], sh_reg[DATA_WIDTH-1:1]};
      default: sh_next = sh_reg << 1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sh_op       <= ALU_SLL;
      sh_reg      <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      ALUResult   <= '0;
      BranchTaken <= 1'b0;
    end else if (accept) begin
      // Covers both a fresh op in IDLE and a back-to-back op in DONE.
      if (is_shift(op_in) && (shamt_in != '0)) begin
        sh_reg    <= SrcA;
        cnt       <= shamt_in;
        sh_op     <= op_in;
        out_valid <= 1'b0;
        state     <= S_SHIFT;
      end else begin
        ALUResult   <= core_result;
        BranchTaken <= core_branch;
        out_valid   <= 1'b1;
        state       <= S_DONE;
      end
    end else begin
      case (state)
        S_SHIFT: begin
          sh_reg <= sh_next;
          cnt    <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            ALUResult   <= sh_next;
            BranchTaken <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Purpose: directed self-checking bench for alu_seq_exec (DATA_WIDTH=32).
// Latency: n/a.
// Backpressure: exercised explicitly via out_ready.
module tb_alu_seq_exec;

  localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR   = 4'b0011, OP_XOR = 4'b0100, OP_SLL = 4'b0101,
                         OP_SRL  = 4'b0110, OP_SRA = 4'b0111, OP_SLT = 4'b1000,
                         OP_SLT2 = 4'b1001, OP_ADD2 = 4'b1010, OP_BEQ = 4'b1011,
                         OP_BNE  = 4'b1100, OP_BLT = 4'b1101, OP_BGE = 4'b1110,
                         OP_PASSB = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        BranchTaken;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Operation   (Operation),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (ALUResult),
    .BranchTaken (BranchTaken)
  );

  // Drive one op at a negedge, let one posedge accept it, drop in_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Operation = 4'h0; SrcA = '0; SrcB = '0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (ALUResult !== 32'h0) $display("FAIL reset_result got %h want 0", ALUResult); else n_pass++;
    n_total++;
    if (BranchTaken !== 1'b0) $display("FAIL reset_branch got %b want 0", BranchTaken); else n_pass++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    issue(OP_ADD, 32'd5, 32'd7);
    n_total++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd12 || BranchTaken !== 1'b0)
      $display("FAIL add got v=%b r=%h b=%b want v=1 r=0000000c b=0", out_valid, ALUResult, BranchTaken);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL add_consumed got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_arith();
    logic [3:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [31:0] exp [8];
    ops = '{OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_PASSB, OP_ADD2, OP_SLT2};
    as  = '{32'h0, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'hDEADBEEF, 32'd3, 32'd1};
    bs  = '{32'h1, 32'h1, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h12345000, 32'd4, 32'hFFFFFFFF};
    exp = '{32'hFFFFFFFF, 32'h1, 32'h0000F000, 32'h0000FFF0, 32'h00000FF0, 32'h12345000, 32'd7, 32'h0};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_total++;
      if (out_valid !== 1'b1 || ALUResult !== exp[i] || BranchTaken !== 1'b0)
        $display("FAIL arith[%0d] op=%b got v=%b r=%h b=%b want v=1 r=%h b=0",
                 i, ops[i], out_valid, ALUResult, BranchTaken, exp[i]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_shift();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    int          lat_exp [4];
    int          lat;
    logic        rdy_low;
    ops = '{OP_SRA, OP_SLL, OP_SRL, OP_SRL};
    as  = '{32'h80000000, 32'h1, 32'h0000ABCD, 32'h80000000};
    bs  = '{32'h21, 32'd31, 32'h20, 32'd4};
    exp = '{32'hC0000000, 32'h80000000, 32'h0000ABCD, 32'h08000000};
    lat_exp = '{2, 32, 1, 5};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      lat = 1;
      rdy_low = 1'b1;
      while (out_valid !== 1'b1 && lat < 100) begin
        if (in_ready !== 1'b0) rdy_low = 1'b0;
        @(negedge clk);
        lat++;
      end
      n_total++;
      if (lat !== lat_exp[i]) $display("FAIL shift_lat[%0d] got %0d want %0d", i, lat, lat_exp[i]); else n_pass++;
      n_total++;
      if (ALUResult !== exp[i] || BranchTaken !== 1'b0)
        $display("FAIL shift_res[%0d] got r=%h b=%b want r=%h b=0", i, ALUResult, BranchTaken, exp[i]);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if (rdy_low !== 1'b1) $display("FAIL shift_in_ready got high during SHIFT want 0"); else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [3:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic        exp [5];
    ops = '{OP_BGE, OP_BLT, OP_BEQ, OP_BNE, OP_BGE};
    as  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'd9, 32'd9};
    bs  = '{32'h0, 32'h0, 32'd9, 32'd9, 32'd9};
    exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_total++;
      if (out_valid !== 1'b1 || BranchTaken !== exp[i] || ALUResult !== {31'b0, exp[i]})
        $display("FAIL branch[%0d] op=%b got v=%b b=%b r=%h want v=1 b=%b r=%h",
                 i, ops[i], out_valid, BranchTaken, ALUResult, exp[i], {31'b0, exp[i]});
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp = '{32'd2, 32'd4, 32'd7};
    Operation = OP_ADD; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || ALUResult !== exp[i])
        $display("FAIL b2b[%0d] got v=%b r=%h want v=1 r=%h", i, out_valid, ALUResult, exp[i]);
      else n_pass++;
      if (i == 0) begin Operation = OP_ADD; SrcA = 32'd2; SrcB = 32'd2; end
      else begin Operation = OP_SUB; SrcA = 32'd10; SrcB = 32'd3; end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic held;
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2);
    held = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Operation = OP_SUB; SrcA = 32'd100 + i; SrcB = 32'd1;
      #1;
      if (out_valid !== 1'b1 || ALUResult !== 32'd3 || in_ready !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (held !== 1'b1 || ALUResult !== 32'd3)
      $display("FAIL bp_hold got r=%h v=%b rdy=%b want r=00000003 v=1 rdy=0", ALUResult, out_valid, in_ready);
    else n_pass++;
    Operation = OP_XOR; SrcA = 32'hF; SrcB = 32'h3;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || ALUResult !== 32'hC)
      $display("FAIL bp_new_op got v=%b r=%h want v=1 r=0000000c", out_valid, ALUResult);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    logic stale;
    issue(OP_SLL, 32'h1, 32'd20);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_total++;
    if (stale !== 1'b0 || ALUResult !== 32'h0)
      $display("FAIL rst_stale got stale=%b r=%h want stale=0 r=00000000", stale, ALUResult);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_shift();
    test_branch();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
